// File: rtl/cs_useq_pkg.sv
// Shared constants for the control-store microsequencer: branch codes,
// address-multiplexer selections and ALU flag positions.
package cs_useq_pkg;

    localparam logic [2:0] BR_NEXT   = 3'b000;
    localparam logic [2:0] BR_JUMP   = 3'b001;
    localparam logic [2:0] BR_CJUMP  = 3'b010;
    localparam logic [2:0] BR_DECODE = 3'b011;
    localparam logic [2:0] BR_CALL   = 3'b100;
    localparam logic [2:0] BR_RETURN = 3'b101;

    localparam logic [1:0] SEL_NEXT   = 2'b00;
    localparam logic [1:0] SEL_JUMP   = 2'b01;
    localparam logic [1:0] SEL_DECODE = 2'b10;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    function automatic logic cond_met(input logic [3:0] flags,
                                      input logic [1:0] cond_sel,
                                      input logic       cond_pol);
        return flags[cond_sel] == cond_pol;
    endfunction

endpackage

// File: rtl/cs_return_stack.sv
// Return-address LIFO; top is combinational, push/pop take effect at the edge.
// Push when full and pop when empty are ignored; the caller flags them.
module cs_return_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_dat,
    output logic [WIDTH-1:0] top_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra pointer bit so that full and empty are distinct states.
    logic [AW:0]      ptr;
    logic [AW-1:0]    top_idx;
    logic [WIDTH-1:0] mem [DEPTH];

    assign full    = (ptr == (AW+1)'(DEPTH));
    assign empty   = (ptr == '0);
    assign top_idx = ptr[AW-1:0] - AW'(1);
    assign top_dat = mem[top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (push && !full) begin
            ptr <= ptr + (AW+1)'(1);
        end else if (pop && !empty) begin
            ptr <= ptr - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[ptr[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/cs_microsequencer.sv
// Micro-PC register, branch decode and return stack feeding the control-store mux.
// Mux controls are combinational in-cycle; Stall_IN freezes uPC, stack and flags.
module cs_microsequencer
    import cs_useq_pkg::*;
#(
    parameter int DIRECTION_BUS_WIDTH = 11,
    parameter int DECODE_BUS_WIDTH    = 8,
    parameter int STACK_DEPTH         = 4
) (
    input  logic                           CS_uSequencer_CLOCK_50,
    input  logic                           CS_uSequencer_RESET_InLow,
    input  logic                           CS_uSequencer_Stall_IN,
    input  logic [2:0]                     CS_uSequencer_Branch_IN,
    input  logic [1:0]                     CS_uSequencer_CondSel_IN,
    input  logic                           CS_uSequencer_CondPol_IN,
    input  logic [3:0]                     CS_uSequencer_Flags_IN,
    input  logic [DIRECTION_BUS_WIDTH-1:0] CS_uSequencer_JumpAddr_IN,
    input  logic [DECODE_BUS_WIDTH-1:0]    CS_uSequencer_Opcode_IN,
    input  logic [DIRECTION_BUS_WIDTH-1:0] CS_uSequencer_Address_IN,
    output logic [DIRECTION_BUS_WIDTH-1:0] CS_uSequencer_uPC_OUT,
    output logic [DIRECTION_BUS_WIDTH-1:0] CS_uSequencer_Next_OUT,
    output logic [DIRECTION_BUS_WIDTH-1:0] CS_uSequencer_Jump_OUT,
    output logic [DECODE_BUS_WIDTH-1:0]    CS_uSequencer_Decode_OUT,
    output logic [1:0]                     CS_uSequencer_Selection_OUT,
    output logic                           CS_uSequencer_Overflow_OUT,
    output logic                           CS_uSequencer_Underflow_OUT
);

    localparam int W = DIRECTION_BUS_WIDTH;

    logic         clk;
    logic         rst_n;
    logic         stall;
    logic [W-1:0] upc;
    logic [W-1:0] upc_inc;
    logic [W-1:0] stack_top;
    logic         stack_full;
    logic         stack_empty;
    logic [1:0]   sel;
    logic [W-1:0] jump;
    logic         call_req;
    logic         ret_req;
    logic         push;
    logic         pop;
    logic         overflow;
    logic         underflow;

    assign clk     = CS_uSequencer_CLOCK_50;
    assign rst_n   = CS_uSequencer_RESET_InLow;
    assign stall   = CS_uSequencer_Stall_IN;
    assign upc_inc = upc + W'(1);

    always_comb begin
        sel      = SEL_NEXT;
        jump     = CS_uSequencer_JumpAddr_IN;
        call_req = 1'b0;
        ret_req  = 1'b0;
        case (CS_uSequencer_Branch_IN)
            BR_JUMP:   sel = SEL_JUMP;
            BR_CJUMP: begin
                if (cond_met(CS_uSequencer_Flags_IN, CS_uSequencer_CondSel_IN,
                             CS_uSequencer_CondPol_IN)) begin
                    sel = SEL_JUMP;
                end
            end
            BR_DECODE: sel = SEL_DECODE;
            BR_CALL: begin
                sel      = SEL_JUMP;
                call_req = 1'b1;
            end
            BR_RETURN: begin
                ret_req = 1'b1;
                // An empty stack falls through to the next address.
                if (!stack_empty) begin
                    sel  = SEL_JUMP;
                    jump = stack_top;
                end
            end
            default:   sel = SEL_NEXT;
        endcase
    end

    assign push = call_req && !stack_full  && !stall;
    assign pop  = ret_req  && !stack_empty && !stall;

    cs_return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (W)
    ) u_stack (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .push_dat (upc_inc),
        .top_dat  (stack_top),
        .full     (stack_full),
        .empty    (stack_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upc       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!stall) begin
            upc <= CS_uSequencer_Address_IN;
            if (call_req && stack_full) begin
                overflow <= 1'b1;
            end
            if (ret_req && stack_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    assign CS_uSequencer_uPC_OUT       = upc;
    assign CS_uSequencer_Next_OUT      = upc_inc;
    assign CS_uSequencer_Jump_OUT      = jump;
    assign CS_uSequencer_Decode_OUT    = CS_uSequencer_Opcode_IN;
    assign CS_uSequencer_Selection_OUT = rst_n ? sel : SEL_NEXT;
    assign CS_uSequencer_Overflow_OUT  = overflow;
    assign CS_uSequencer_Underflow_OUT = underflow;

endmodule

// File: tb/tb_cs_microsequencer.sv
// Closed-loop bench: a control-store address multiplexer feeds Address_IN back.
module tb_cs_microsequencer;
    import cs_useq_pkg::*;

    localparam int W = 11;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         stall = 1'b0;
    logic [2:0]   branch = BR_NEXT;
    logic [1:0]   cond_sel = 2'd0;
    logic         cond_pol = 1'b0;
    logic [3:0]   flags = 4'd0;
    logic [W-1:0] jaddr = '0;
    logic [D-1:0] opcode = '0;
    logic [W-1:0] addr;
    logic [W-1:0] upc, nxt, jmp;
    logic [D-1:0] dec;
    logic [1:0]   sel;
    logic         ovf, unf;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q [$];

    always #5 clk = ~clk;

    // Decode targets sit in the upper half, four words per opcode.
    always_comb begin
        case (sel)
            SEL_JUMP:   addr = jmp;
            SEL_DECODE: addr = (W'(1) << (D + 2)) | (W'(dec) << 2);
            default:    addr = nxt;
        endcase
    end

    cs_microsequencer #(
        .DIRECTION_BUS_WIDTH (W),
        .DECODE_BUS_WIDTH    (D),
        .STACK_DEPTH         (4)
    ) dut (
        .CS_uSequencer_CLOCK_50      (clk),
        .CS_uSequencer_RESET_InLow   (rst_n),
        .CS_uSequencer_Stall_IN      (stall),
        .CS_uSequencer_Branch_IN     (branch),
        .CS_uSequencer_CondSel_IN    (cond_sel),
        .CS_uSequencer_CondPol_IN    (cond_pol),
        .CS_uSequencer_Flags_IN      (flags),
        .CS_uSequencer_JumpAddr_IN   (jaddr),
        .CS_uSequencer_Opcode_IN     (opcode),
        .CS_uSequencer_Address_IN    (addr),
        .CS_uSequencer_uPC_OUT       (upc),
        .CS_uSequencer_Next_OUT      (nxt),
        .CS_uSequencer_Jump_OUT      (jmp),
        .CS_uSequencer_Decode_OUT    (dec),
        .CS_uSequencer_Selection_OUT (sel),
        .CS_uSequencer_Overflow_OUT  (ovf),
        .CS_uSequencer_Underflow_OUT (unf)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one microinstruction, queue the expected next uPC, compare after the edge.
    task automatic step(input string tag, input logic [2:0] br, input logic [W-1:0] ja,
                        input logic st, input logic [W-1:0] exp_upc);
        logic [W-1:0] e;
        branch = br;
        jaddr  = ja;
        stall  = st;
        exp_q.push_back(exp_upc);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, upc, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with a JUMP on the branch field to exercise the forced selection.
        branch = BR_JUMP;
        jaddr  = 11'h155;
        #12;
        check("rst_upc", upc, 11'h000);
        check("rst_sel", W'(sel), W'(SEL_NEXT));
        check("rst_next", nxt, 11'h001);
        check("rst_ovf", W'(ovf), '0);
        check("rst_unf", W'(unf), '0);
        @(negedge clk);
        rst_n = 1'b1;
        branch = BR_NEXT;
        #1;
        check("next_sel", W'(sel), W'(SEL_NEXT));

        step("next1", BR_NEXT, 11'h000, 1'b0, 11'h001);
        step("next2", BR_NEXT, 11'h000, 1'b0, 11'h002);
        step("next3", BR_NEXT, 11'h000, 1'b0, 11'h003);

        // Conditional jumps on Z, N and V.
        step("jump5a", BR_JUMP, 11'h005, 1'b0, 11'h005);
        cond_sel = 2'd0; cond_pol = 1'b1; flags = 4'b0001;
        step("cjump_z1", BR_CJUMP, 11'h040, 1'b0, 11'h040);
        step("jump5b", BR_JUMP, 11'h005, 1'b0, 11'h005);
        flags = 4'b1110;
        step("cjump_z0", BR_CJUMP, 11'h040, 1'b0, 11'h006);
        cond_sel = 2'd1; cond_pol = 1'b0; flags = 4'b0000;
        step("cjump_n_clr", BR_CJUMP, 11'h077, 1'b0, 11'h077);
        cond_sel = 2'd3; cond_pol = 1'b1; flags = 4'b0111;
        step("cjump_v_clr", BR_CJUMP, 11'h033, 1'b0, 11'h078);

        // Opcode decode through the multiplexer.
        opcode = 8'h3C;
        branch = BR_DECODE;
        #1;
        check("dec_sel", W'(sel), W'(SEL_DECODE));
        check("dec_addr", addr, 11'h4F0);
        step("dec_upc", BR_DECODE, 11'h000, 1'b0, 11'h4F0);

        // Call and return.
        step("jump20", BR_JUMP, 11'h020, 1'b0, 11'h020);
        step("call100", BR_CALL, 11'h100, 1'b0, 11'h100);
        step("next101", BR_NEXT, 11'h000, 1'b0, 11'h101);
        branch = BR_RETURN;
        jaddr  = 11'h555;
        #1;
        check("ret_jump", jmp, 11'h021);
        step("ret021", BR_RETURN, 11'h555, 1'b0, 11'h021);

        // Return with empty stack.
        branch = BR_RETURN;
        jaddr  = 11'h3FF;
        #1;
        check("unf_sel", W'(sel), W'(SEL_NEXT));
        check("unf_jump", jmp, 11'h3FF);
        step("unf_upc", BR_RETURN, 11'h3FF, 1'b0, 11'h022);
        check("unf_flag", W'(unf), W'(1));

        // Five nested calls on a four-deep stack.
        step("call1", BR_CALL, 11'h200, 1'b0, 11'h200);
        step("call2", BR_CALL, 11'h210, 1'b0, 11'h210);
        step("call3", BR_CALL, 11'h220, 1'b0, 11'h220);
        step("call4", BR_CALL, 11'h230, 1'b0, 11'h230);
        check("ovf_clr", W'(ovf), '0);
        step("call5", BR_CALL, 11'h240, 1'b0, 11'h240);
        check("ovf_set", W'(ovf), W'(1));
        step("ret4", BR_RETURN, 11'h000, 1'b0, 11'h221);
        step("ret3", BR_RETURN, 11'h000, 1'b0, 11'h211);
        step("ret2", BR_RETURN, 11'h000, 1'b0, 11'h201);
        step("ret1", BR_RETURN, 11'h000, 1'b0, 11'h023);

        // Call held by stall for three edges pushes exactly once.
        step("stall1", BR_CALL, 11'h300, 1'b1, 11'h023);
        step("stall2", BR_CALL, 11'h300, 1'b1, 11'h023);
        step("stall3", BR_CALL, 11'h300, 1'b1, 11'h023);
        step("stall_rel", BR_CALL, 11'h300, 1'b0, 11'h300);
        step("stall_ret", BR_RETURN, 11'h000, 1'b0, 11'h024);
        branch = BR_RETURN;
        #1;
        check("stall_once", W'(sel), W'(SEL_NEXT));

        // Top-of-space wrap.
        step("jump7ff", BR_JUMP, 11'h7FF, 1'b0, 11'h7FF);
        check("wrap_next", nxt, 11'h000);
        step("wrap_upc", BR_NEXT, 11'h000, 1'b0, 11'h000);

        // Reset in the middle of a cycle, with a return pending.
        step("call150", BR_CALL, 11'h150, 1'b0, 11'h150);
        branch = BR_JUMP;
        jaddr  = 11'h0AA;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_upc", upc, 11'h000);
        check("mid_rst_sel", W'(sel), W'(SEL_NEXT));
        check("mid_rst_next", nxt, 11'h001);
        check("mid_rst_ovf", W'(ovf), '0);
        check("mid_rst_unf", W'(unf), '0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_ret", BR_RETURN, 11'h0AA, 1'b0, 11'h001);
        check("post_rst_unf", W'(unf), W'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
